game_controller: RTL and testbench
==================================

// Module: game_controller
// PURPOSE
//  Top-level Whac-A-Mole game sequencer. Owns the game state machine, drives the
//  countdown timer's reset/enable, detects end of game from the timer outputs,
//  keeps the score and the session high score. Sits between debounced buttons,
//  mole-hit logic and the timer; its outputs feed the display and mole spawner.
// PARAMETERS
//  GAME_LENGTH_SECONDS  20     game length; sizes timer_seconds input
//  CLKS_PER_MS          50000  clk cycles per millisecond (internal ms tick)
//  GET_READY_MS         3000   ms spent in READY before play starts (>=1)
//  GAMEOVER_HOLD_MS     5000   ms OVER is held before auto-return to IDLE (>=1)
//  SCORE_MAX            999    score saturation value
// PORTS
//  clk            in   1    system clock
//  rst            in   1    asynchronous, active-low reset
//  start_btn      in   1    debounced, synchronized level; rising edge = start
//  pause_btn      in   1    debounced, synchronized level; rising edge = toggle pause
//  hit            in   1    1-cycle pulse: mole hit
//  miss           in   1    1-cycle pulse: missed swing
//  timer_seconds  in   $clog2(GAME_LENGTH_SECONDS)  timer seconds output
//  timer_ms       in   10   timer milliseconds output
//  timer_rst      out  1    active-high sync reset to timer
//  timer_enable   out  1    timer enable
//  state          out  3    IDLE=0 READY=1 PLAY=2 PAUSE=3 OVER=4
//  game_active    out  1    1 in PLAY only
//  score          out  10   current score
//  high_score     out  10   best score since rst
//  new_high       out  1    1 in OVER when this game set a new high score
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, score=0, high_score=0, new_high=0,
//   edge regs=0, ms tick and phase counters=0. timer_rst=1, timer_enable=0.
//  Edges: start_rise = start_btn & ~start_q; pause_rise likewise; *_q registered
//   every cycle. Transition takes effect on the clock edge where rise is seen.
//  Outputs are decoded from the state register (no extra latency):
//   timer_rst=1 in IDLE,READY; timer_enable=1 in PLAY only; game_active=(PLAY).
//  ms tick: counter 0..CLKS_PER_MS-1, runs only in READY and OVER, cleared on
//   every state change; tick pulses on wrap. Phase counter counts ticks.
//  IDLE : start_rise -> READY; score<=0, new_high<=0. Others ignored.
//  READY: after GET_READY_MS ticks -> PLAY. hit/miss/pause ignored.
//  PLAY : hit&~miss -> score+1 saturating at SCORE_MAX; miss&~hit -> score-1
//   saturating at 0; hit&miss same cycle -> unchanged. pause_rise -> PAUSE.
//   expired = (timer_seconds==0 && timer_ms==999) -> OVER; expired wins over
//   pause_rise and hit/miss in the same cycle (score not updated that cycle).
//  PAUSE: timer frozen; hit/miss ignored; pause_rise -> PLAY. start ignored.
//  OVER : on entry cycle, if score>high_score: high_score<=score, new_high<=1.
//   start_rise -> READY (score<=0, new_high<=0); else after GAMEOVER_HOLD_MS
//   ticks -> IDLE (score and new_high kept until next start).
//  start_rise in READY/PLAY/PAUSE ignored; only rst aborts a game.
//  Illegal state encodings (5-7) -> IDLE next cycle.
//  high_score cleared only by rst.
// TESTING  (CLKS_PER_MS=4, GET_READY_MS=3, GAMEOVER_HOLD_MS=5, GAME_LENGTH_SECONDS=4)
//  rst low mid-PLAY with score=7 -> state=0, score=0, high_score=0, timer_rst=1
//   immediately (async), timer_enable=0.
//  start rise in IDLE -> state=1 next edge; state=2 exactly 12 clks later;
//   timer_rst falls and timer_enable rises the same cycle.
//  PLAY: 5 hits, 2 misses, 1 hit+miss same cycle -> score=3; 3 more misses from
//   score=1 -> score=0 (no underflow); preload 998 + 3 hits -> 999.
//  pause rise in PLAY -> state=3, timer_enable=0, 4 hits ignored; pause rise
//   -> state=2, score unchanged.
//  timer_seconds=0, timer_ms=999 with hit same cycle -> state=4, score
//   unchanged; score 12 > high 8 -> high_score=12, new_high=1; 20 clks -> IDLE.
//  OVER with score 5 < high 12 -> new_high=0, high kept; start rise in OVER
//   -> READY, score=0, high_score=12.

Source files
------------

// File: rtl/game_controller.sv
// Whac-A-Mole game sequencer.
// The game FSM drives the external countdown timer and detects end of game
// from the timer outputs. It keeps the current score and the session high
// score. The timed phases (READY and OVER) are measured with an internal
// millisecond tick that counts clk cycles.
//
// Button handshake: start_btn and pause_btn are debounced, synchronized levels.
// A press is a rising edge, found by comparing each button with its value
// registered on the previous cycle, and it acts on the clock edge where it is
// seen. hit and miss are single-cycle pulses that are sampled on every edge
// while the game is in PLAY. No input is ever back-pressured.
module game_controller #(
  parameter int GAME_LENGTH_SECONDS = 20,
  parameter int CLKS_PER_MS         = 50000,
  parameter int GET_READY_MS        = 3000,
  parameter int GAMEOVER_HOLD_MS    = 5000,
  parameter int SCORE_MAX           = 999
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_btn,
  input  logic                                   pause_btn,
  input  logic                                   hit,
  input  logic                                   miss,
  input  logic [$clog2(GAME_LENGTH_SECONDS)-1:0] timer_seconds,
  input  logic [9:0]                             timer_ms,
  output logic                                   timer_rst,
  output logic                                   timer_enable,
  output logic [2:0]                             state,
  output logic                                   game_active,
  output logic [9:0]                             score,
  output logic [9:0]                             high_score,
  output logic                                   new_high
);

  // Millisecond tick counter width (at least one bit, even for CLKS_PER_MS=1).
  localparam int MSW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  // The phase counter must hold the longer of the two timed phases.
  localparam int PMAX = (GET_READY_MS > GAMEOVER_HOLD_MS) ? GET_READY_MS : GAMEOVER_HOLD_MS;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [MSW-1:0] MS_LAST    = MSW'(CLKS_PER_MS - 1);
  localparam logic [PW-1:0]  READY_LAST = PW'(GET_READY_MS - 1);
  localparam logic [PW-1:0]  OVER_LAST  = PW'(GAMEOVER_HOLD_MS - 1);
  localparam logic [9:0]     SMAX       = 10'(SCORE_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t         cur;
  state_t         nxt;
  logic           start_q;
  logic           pause_q;
  logic           start_rise;
  logic           pause_rise;
  logic           expired;
  logic           ms_run;
  logic           tick;
  logic           state_chg;
  logic [MSW-1:0] ms_cnt;
  logic [PW-1:0]  phase_cnt;

  assign start_rise = start_btn & ~start_q;
  assign pause_rise = pause_btn & ~pause_q;

  // The timer has run out when it reads 0 s and 999 ms.
  assign expired    = (timer_seconds == '0) && (timer_ms == 10'd999);

  assign ms_run     = (cur == S_READY) || (cur == S_OVER);
  assign tick       = ms_run && (ms_cnt == MS_LAST);
  assign state_chg  = (nxt != cur);

  // Register the button levels every cycle so that rising edges can be detected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      start_q <= start_btn;
      pause_q <= pause_btn;
    end
  end

  // Game state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= S_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // Next-state decode. The timer running out beats a pause press in PLAY, and
  // a start press beats the hold timeout in OVER.
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE: begin
        if (start_rise) nxt = S_READY;
      end
      S_READY: begin
        if (tick && (phase_cnt == READY_LAST)) nxt = S_PLAY;
      end
      S_PLAY: begin
        if (expired)         nxt = S_OVER;
        else if (pause_rise) nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (pause_rise) nxt = S_PLAY;
      end
      S_OVER: begin
        if (start_rise)                                nxt = S_READY;
        else if (tick && (phase_cnt == OVER_LAST))     nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Millisecond prescaler. It runs only in the timed states and restarts from
  // zero whenever the state changes, so each phase begins with a full millisecond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms_cnt <= '0;
    end else if (state_chg || !ms_run || tick) begin
      ms_cnt <= '0;
    end else begin
      ms_cnt <= ms_cnt + MSW'(1);
    end
  end

  // Count the milliseconds spent in the current timed phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_cnt <= '0;
    end else if (state_chg || !ms_run) begin
      phase_cnt <= '0;
    end else if (tick) begin
      phase_cnt <= phase_cnt + PW'(1);
    end
  end

  // Score and high-score bookkeeping. The high score is compared on the edge
  // that enters OVER, while the score is frozen, so new_high is already valid
  // on the first OVER cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score      <= '0;
      high_score <= '0;
      new_high   <= 1'b0;
    end else begin
      if (((cur == S_IDLE) || (cur == S_OVER)) && start_rise) begin
        score    <= '0;
        new_high <= 1'b0;
      end else if (cur == S_PLAY) begin
        if (expired) begin
          if (score > high_score) begin
            high_score <= score;
            new_high   <= 1'b1;
          end
        end else if (hit && !miss) begin
          if (score < SMAX) score <= score + 10'd1;
        end else if (miss && !hit) begin
          if (score != 10'd0) score <= score - 10'd1;
        end
      end
    end
  end

  // Outputs are decoded directly from the state register.
  always_comb begin
    state        = cur;
    timer_rst    = 1'b0;
    timer_enable = 1'b0;
    game_active  = 1'b0;
    case (cur)
      S_IDLE, S_READY: timer_rst = 1'b1;
      S_PLAY: begin
        timer_enable = 1'b1;
        game_active  = 1'b1;
      end
      S_PAUSE, S_OVER: ;
      default: timer_rst = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_game_controller.sv
// Testbench for game_controller using short, parameterized phase lengths.
module tb_game_controller;

  localparam int GLS   = 4;
  localparam int CPM   = 4;
  localparam int GRMS  = 3;
  localparam int GOMS  = 5;
  localparam int SMAXV = 999;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READY = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start_btn;
  logic                    pause_btn;
  logic                    hit;
  logic                    miss;
  logic [$clog2(GLS)-1:0]  timer_seconds;
  logic [9:0]              timer_ms;
  logic                    timer_rst;
  logic                    timer_enable;
  logic [2:0]              state;
  logic                    game_active;
  logic [9:0]              score;
  logic [9:0]              high_score;
  logic                    new_high;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [12:0] exp_q[$];
  logic [9:0]  ref_score;

  game_controller #(
    .GAME_LENGTH_SECONDS (GLS),
    .CLKS_PER_MS         (CPM),
    .GET_READY_MS        (GRMS),
    .GAMEOVER_HOLD_MS    (GOMS),
    .SCORE_MAX           (SMAXV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_btn     (start_btn),
    .pause_btn     (pause_btn),
    .hit           (hit),
    .miss          (miss),
    .timer_seconds (timer_seconds),
    .timer_ms      (timer_ms),
    .timer_rst     (timer_rst),
    .timer_enable  (timer_enable),
    .state         (state),
    .game_active   (game_active),
    .score         (score),
    .high_score    (high_score),
    .new_high      (new_high)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference score update.
  function automatic logic [9:0] next_score(input logic [9:0] s, input logic h, input logic m);
    if (h && !m) return (s >= 10'(SMAXV)) ? s : s + 10'd1;
    if (m && !h) return (s == 10'd0) ? s : s - 10'd1;
    return s;
  endfunction

  // Drive one cycle of inputs; the expected {state, score} goes through the
  // scoreboard queue and is compared once the edge has happened.
  task automatic drive(input string tag, input logic h, input logic m, input logic pb,
                       input logic sb, input logic [2:0] es, input logic [9:0] esc);
    hit       = h;
    miss      = m;
    pause_btn = pb;
    start_btn = sb;
    exp_q.push_back({es, esc});
    step();
    check(tag, {19'd0, state, score}, {19'd0, exp_q.pop_front()});
  endtask

  task automatic play(input string tag, input logic h, input logic m);
    ref_score = next_score(ref_score, h, m);
    drive(tag, h, m, 1'b0, 1'b0, ST_PLAY, ref_score);
  endtask

  // Step until state reaches target (bounded) and check the number of cycles.
  task automatic wait_state(input string tag, input logic [2:0] target, input int exp_n);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((state !== target) && (n < 64));
    check(tag, n, exp_n);
  endtask

  // Press start, hold hit/pause through READY, and land in PLAY with score 0.
  task automatic start_game();
    drive("start_to_ready", 1'b0, 1'b0, 1'b0, 1'b1, ST_READY, 10'd0);
    check("ready_new_high", new_high, 1'b0);
    check("ready_timer_rst", timer_rst, 1'b1);
    start_btn = 1'b0;
    hit       = 1'b1;
    pause_btn = 1'b1;
    wait_state("ready_len", ST_PLAY, GRMS * CPM);
    check("play_timer_rst", timer_rst, 1'b0);
    check("play_timer_en", timer_enable, 1'b1);
    check("play_active", game_active, 1'b1);
    check("play_entry_score", score, 10'd0);
    hit       = 1'b0;
    pause_btn = 1'b0;
    ref_score = 10'd0;
  endtask

  task automatic expire_cycle(input string tag, input logic h, input logic pb);
    timer_seconds = '0;
    timer_ms      = 10'd999;
    drive(tag, h, 1'b0, pb, 1'b0, ST_OVER, ref_score);
    timer_seconds = 2'd3;
    timer_ms      = 10'd0;
    hit           = 1'b0;
    pause_btn     = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    start_btn     = 1'b0;
    pause_btn     = 1'b0;
    hit           = 1'b0;
    miss          = 1'b0;
    timer_seconds = 2'd3;
    timer_ms      = 10'd0;
    ref_score     = 10'd0;
    repeat (2) step();

    check("rst_state", state, ST_IDLE);
    check("rst_score", score, 10'd0);
    check("rst_high", high_score, 10'd0);
    check("rst_new_high", new_high, 1'b0);
    check("rst_timer_rst", timer_rst, 1'b1);
    check("rst_timer_en", timer_enable, 1'b0);
    check("rst_active", game_active, 1'b0);

    rst = 1'b1;
    step();
    drive("idle_hit", 1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE, 10'd0);
    drive("idle_pause", 1'b0, 1'b0, 1'b1, 1'b0, ST_IDLE, 10'd0);
    drive("idle_quiet", 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE, 10'd0);

    // Game A: mixed scoring, ignored start, then asynchronous abort.
    start_game();
    for (int i = 0; i < 5; i++) play("hit", 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) play("miss", 1'b0, 1'b1);
    play("hit_and_miss", 1'b1, 1'b1);
    check("score_mix", score, 10'd3);
    for (int i = 0; i < 4; i++) play("hit", 1'b1, 1'b0);
    drive("play_start_ign", 1'b0, 1'b0, 1'b0, 1'b1, ST_PLAY, ref_score);
    start_btn = 1'b0;
    check("score_seven", score, 10'd7);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_state", state, ST_IDLE);
    check("async_score", score, 10'd0);
    check("async_high", high_score, 10'd0);
    check("async_timer_rst", timer_rst, 1'b1);
    check("async_timer_en", timer_enable, 1'b0);
    step();
    rst = 1'b1;
    step();

    // Game B: underflow, saturation, pause.
    start_game();
    play("hit", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) play("miss_floor", 1'b0, 1'b1);
    check("score_floor", score, 10'd0);
    for (int i = 0; i < 998; i++) play("ramp", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) play("hit_sat", 1'b1, 1'b0);
    check("score_sat", score, 10'd999);
    drive("pause_enter", 1'b0, 1'b0, 1'b1, 1'b0, ST_PAUSE, ref_score);
    check("pause_timer_en", timer_enable, 1'b0);
    check("pause_active", game_active, 1'b0);
    for (int i = 0; i < 4; i++) drive("pause_hit", 1'b1, 1'b0, 1'b1, 1'b0, ST_PAUSE, ref_score);
    drive("pause_release", 1'b0, 1'b0, 1'b0, 1'b0, ST_PAUSE, ref_score);
    drive("pause_resume", 1'b0, 1'b0, 1'b1, 1'b0, ST_PLAY, ref_score);
    check("resume_timer_en", timer_enable, 1'b1);
    pause_btn = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("high_after_rst", high_score, 10'd0);

    // Game C: score 8, expiry beats pause, first high score.
    start_game();
    for (int i = 0; i < 8; i++) play("hit", 1'b1, 1'b0);
    expire_cycle("expire_vs_pause", 1'b0, 1'b1);
    check("c_high", high_score, 10'd8);
    check("c_new_high", new_high, 1'b1);
    check("over_timer_en", timer_enable, 1'b0);
    check("over_timer_rst", timer_rst, 1'b0);
    wait_state("c_hold_len", ST_IDLE, GOMS * CPM);

    // Game D: expiry beats a hit, new high 12, hold back to IDLE.
    start_game();
    for (int i = 0; i < 12; i++) play("hit", 1'b1, 1'b0);
    expire_cycle("expire_vs_hit", 1'b1, 1'b0);
    check("d_score", score, 10'd12);
    check("d_high", high_score, 10'd12);
    check("d_new_high", new_high, 1'b1);
    wait_state("d_hold_len", ST_IDLE, GOMS * CPM);
    check("idle_score_kept", score, 10'd12);
    check("idle_new_high_kept", new_high, 1'b1);

    // Game E: lower score, then restart from OVER.
    start_game();
    for (int i = 0; i < 5; i++) play("hit", 1'b1, 1'b0);
    expire_cycle("e_expire", 1'b0, 1'b0);
    check("e_new_high", new_high, 1'b0);
    check("e_high", high_score, 10'd12);
    drive("over_start", 1'b0, 1'b0, 1'b0, 1'b1, ST_READY, 10'd0);
    check("restart_high", high_score, 10'd12);
    check("restart_new_high", new_high, 1'b0);
    start_btn = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
